uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO, configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits) and back-to-back frame transmission. It sits between any byte-producing client (command encoder, debug streamer) and the FPGA TX pin. It replaces the single-frame transmitter wherever bursts must be queued without the client stalling per byte.

---
 rtl/uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter with a queued input stage. Frame format is
//            configurable (5-9 data bits, none/odd/even parity, 1 or 2 stop
//            bits) and queued words are sent back-to-back with no idle gap.
//            Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; leave it
//            undefined for a single holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BITS_N-1:0]           data_tx,
    input  logic                        valid,
    output logic                        ready,
    output logic                        uart_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        baud_trigger
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(BITS_N - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (BITS_N < 5 || BITS_N > 9) begin : g_bad_bits_n
        $error("uart_tx_fifo: BITS_N must be in 5..9");
    end
    if (PARITY_TYPE < 0 || PARITY_TYPE > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY_TYPE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    // Handshake between the input stage and the serialiser
    logic              push;
    logic              pop;
    logic              q_empty;
    logic [BITS_N-1:0] head;

    assign push = valid && ready;

`ifdef UART_TX_FIFO_EN
    // ------------------------------------------------------------------------
    // Input stage: circular FIFO of FIFO_DEPTH words
    // ------------------------------------------------------------------------
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [BITS_N-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CW-1:0]     count_q;

    assign ready      = (count_q != CW'(FIFO_DEPTH));
    assign q_empty    = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign fifo_count = count_q;

    // Storage array; contents need no reset because count_q gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_tx;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
`else
    // ------------------------------------------------------------------------
    // Input stage: single holding register
    // ------------------------------------------------------------------------
    logic [BITS_N-1:0] hold_q;
    logic              full_q;

    assign ready      = !full_q;
    assign q_empty    = !full_q;
    assign head       = hold_q;
    assign fifo_count = {{(CW-1){1'b0}}, full_q};

    // Push only happens when empty and pop only when full, so they never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else if (push) begin
            hold_q <= data_tx;
            full_q <= 1'b1;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_cnt_q;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic [BITS_N-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              head_parity;

    assign baud_trigger = (baud_cnt_q == BAUD_LAST) && (state_q != ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    // Odd parity makes data ones + parity odd, so the bit is the XNOR of the data
    assign head_parity  = (PARITY_TYPE == 1) ? ~^head : ^head;

    // Bit-period counter: parked at 0 while idle, wraps on every trigger
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_IDLE || baud_trigger) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
        end
    end

    // Frame state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
        end
    end

    // Next-state logic; a pop loads the head word and its parity in one step
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    shift_d    = head;
                    parity_d   = head_parity;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_trigger) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (baud_trigger) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY_TYPE != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_trigger) begin
                    stop_idx_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_trigger) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        if (!q_empty) begin
                            pop        = 1'b1;
                            shift_d    = head;
                            parity_d   = head_parity;
                            bit_idx_d  = '0;
                            stop_idx_d = 1'b0;
                            state_d    = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is a pure decode of registered state, idle high
    always_comb begin
        uart_out = 1'b1;
        case (state_q)
            ST_START:  uart_out = 1'b0;
            ST_DATA:   uart_out = shift_q[0];
            ST_PARITY: uart_out = parity_q;
            default:   uart_out = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo. Four instances
//            cover 8N1, 8E1, 8O1 and 9N2 frames at 4 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]      da, db, dc;
    logic [8:0]      dd;
    logic [3:0]      vld, rdy, uo, bz, bt;
    logic [3:0][4:0] fc;

    int         total = 0;
    int         bad   = 0;
    int         cur   = 0;
    logic [8:0] pq[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
        .clk(clk), .rst(rst), .data_tx(da), .valid(vld[0]), .ready(rdy[0]),
        .uart_out(uo[0]), .busy(bz[0]), .fifo_count(fc[0]), .baud_trigger(bt[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_e (
        .clk(clk), .rst(rst), .data_tx(db), .valid(vld[1]), .ready(rdy[1]),
        .uart_out(uo[1]), .busy(bz[1]), .fifo_count(fc[1]), .baud_trigger(bt[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_o (
        .clk(clk), .rst(rst), .data_tx(dc), .valid(vld[2]), .ready(rdy[2]),
        .uart_out(uo[2]), .busy(bz[2]), .fifo_count(fc[2]), .baud_trigger(bt[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(9), .PARITY_TYPE(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_9 (
        .clk(clk), .rst(rst), .data_tx(dd), .valid(vld[3]), .ready(rdy[3]),
        .uart_out(uo[3]), .busy(bz[3]), .fifo_count(fc[3]), .baud_trigger(bt[3]));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word on the instance under test
    task automatic drive(input logic [8:0] w, input logic v);
        case (cur)
            0:       da = w[7:0];
            1:       db = w[7:0];
            2:       dc = w[7:0];
            default: dd = w;
        endcase
        vld[cur] = v;
    endtask

    task automatic load();
        if (pq.size() > 0) drive(pq[0], 1'b1);
        else               drive(9'h000, 1'b0);
    endtask

    // One clock with valid/ready handshake from the pending-word queue
    task automatic step();
        logic acc;
        acc = vld[cur] && rdy[cur];
        @(posedge clk);
        #1;
        if (acc) void'(pq.pop_front());
        load();
    endtask

    // Check every clock of nb bit periods; bits[b] is the level of period b
    task automatic frame_check(input string tag, input logic [15:0] bits, input int nb);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < CPB; c++) begin
                chk({tag, "_line"}, 16'(uo[cur]), 16'(bits[b]));
                chk({tag, "_trig"}, 16'(bt[cur]), 16'(c == CPB - 1));
                chk({tag, "_busy"}, 16'(bz[cur]), 16'd1);
                step();
            end
        end
    endtask

    initial begin
        int acc;
        int lows;
        rst = 1'b1;
        da = '0; db = '0; dc = '0; dd = '0;
        vld = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_uart_out", 16'(uo[k]),  16'd1);
            chk("rst_ready",    16'(rdy[k]), 16'd1);
            chk("rst_busy",     16'(bz[k]),  16'd0);
            chk("rst_count",    16'(fc[k]),  16'd0);
            chk("rst_trig",     16'(bt[k]),  16'd0);
        end
        rst = 1'b0;

        // 8N1 0x55: accepted at edge 1, start bit from edge 2
        cur = 0;
        pq.push_back(9'h055);
        load();
        step();
        chk("n1_count_acc", 16'(fc[0]), 16'd1);
        chk("n1_line_idle", 16'(uo[0]), 16'd1);
        chk("n1_busy_idle", 16'(bz[0]), 16'd0);
        step();
        chk("n1_count_pop", 16'(fc[0]), 16'd0);
        frame_check("n1_55", 16'h02AA, 10);
        chk("n1_busy_end", 16'(bz[0]), 16'd0);
        chk("n1_line_end", 16'(uo[0]), 16'd1);

        // 8E1 0x07: three ones -> parity bit 1
        cur = 1;
        pq.push_back(9'h007);
        load();
        step();
        step();
        frame_check("e1_07", 16'h060E, 11);
        chk("e1_busy_end", 16'(bz[1]), 16'd0);

        // 8O1 0x07: three ones -> parity bit 0
        cur = 2;
        pq.push_back(9'h007);
        load();
        step();
        step();
        frame_check("o1_07", 16'h040E, 11);
        chk("o1_busy_end", 16'(bz[2]), 16'd0);

        // 9N2 0x1FF: start, nine ones, two stop bits
        cur = 3;
        pq.push_back(9'h1FF);
        load();
        step();
        step();
        frame_check("n2_1ff", 16'h0FFE, 12);
        chk("n2_busy_end", 16'(bz[3]), 16'd0);
        chk("n2_line_end", 16'(uo[3]), 16'd1);

        // Back-to-back frames A1, B2, C3 with no gap between stop and start
        cur = 0;
        pq.push_back(9'h0A1);
        pq.push_back(9'h0B2);
        pq.push_back(9'h0C3);
        load();
        step();
        chk("b2b_count_1", 16'(fc[0]), 16'd1);
        step();
`ifdef UART_TX_FIFO_EN
        chk("b2b_count_2", 16'(fc[0]), 16'd1);
`else
        chk("b2b_count_2", 16'(fc[0]), 16'd0);
`endif
        frame_check("b2b_a1", 16'h0342, 10);
        frame_check("b2b_b2", 16'h0364, 10);
        frame_check("b2b_c3", 16'h0386, 10);
        chk("b2b_busy_end",  16'(bz[0]), 16'd0);
        chk("b2b_count_end", 16'(fc[0]), 16'd0);
        chk("b2b_queue_end", 16'(pq.size()), 16'd0);

        // Hold valid for 20 cycles while a frame is on the line
        pq.push_back(9'h000);
        load();
        step();
        step();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(9'(8'h10 + i), 1'b1);
            if (rdy[0]) acc++;
            @(posedge clk);
            #1;
        end
        drive(9'h000, 1'b0);
`ifdef UART_TX_FIFO_EN
        chk("full_accepted", 16'(acc),   16'd16);
        chk("full_count",    16'(fc[0]), 16'd16);
`else
        chk("full_accepted", 16'(acc),   16'd1);
        chk("full_count",    16'(fc[0]), 16'd1);
`endif
        chk("full_ready", 16'(rdy[0]), 16'd0);
        chk("full_busy",  16'(bz[0]),  16'd1);

        // Reset in the middle of the data bits flushes everything
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_line",  16'(uo[0]),  16'd1);
        chk("mid_rst_count", 16'(fc[0]),  16'd0);
        chk("mid_rst_busy",  16'(bz[0]),  16'd0);
        chk("mid_rst_ready", 16'(rdy[0]), 16'd1);
        chk("mid_rst_trig",  16'(bt[0]),  16'd0);
        lows = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (!uo[0] || bz[0]) lows++;
        end
        chk("mid_rst_quiet", 16'(lows), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
